aespim_sbox_sched: RTL and testbench
====================================

# aespim_sbox_sched

Byte-serial scheduler that shares one `aespim_bSbox` instance between two 32-bit word requesters. Requester 0 is the SubBytes/InvSubBytes column path and requester 1 is the key-expansion SubWord path. The block arbitrates round-robin, streams the four bytes of the granted word through the S-box over four cycles, and returns the substituted word with the requester's ID. It sits between the AES PIM round controller and the S-box datapath.

## Interface
- `BYTES`, default 4: bytes per word, legal range 1..4; the word width is `8*BYTES`.
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `req0_valid_i` input 1: requester 0 has a word.
- `req0_ready_o` output 1: requester 0 word accepted this cycle.
- `req0_word_i` input 8*BYTES: requester 0 operand.
- `req0_enc_i` input 1: 1 selects forward S-box, 0 selects inverse.
- `req1_valid_i`, `req1_ready_o`, `req1_word_i`, `req1_enc_i`: same as requester 0, for requester 1.
- `rsp_valid_o` output 1: result available.
- `rsp_ready_i` input 1: consumer takes the result.
- `rsp_id_o` output 1: requester that owns the result.
- `rsp_word_o` output 8*BYTES: substituted word.
- `busy_o` output 1: state is not IDLE.

## Operation
- FSM states are IDLE, SUB, DRAIN and DONE. DRAIN exists only when `AESPIM_SBOX_OUT_REG_EN` is defined.
- **IDLE**
  - `grant = req0` if only req0 is valid, `req1` if only req1 is valid; if both are valid, grant the requester not served last (priority pointer `last`).
  - `reqK_ready_o = (state==IDLE) & grantK & ~rst_i`. It is combinational from valid.
  - On a handshake, latch the word, the enc flag and the ID, set `last = K`, clear the byte counter and move to SUB.
- **SUB**
  - S-box input is `word_q[8*cnt +: 8]`, with `encrypt = enc_q`.
  - Without the macro, write the S-box output into `res_q[8*cnt +: 8]` in the same cycle.
  - Increment `cnt`. When `cnt==BYTES-1`, go to DONE, or to DRAIN when the macro is defined.
  - Bytes are processed LSB first.
- **DRAIN**: the final registered byte is written into `res_q`, then go to DONE.
- **DONE**
  - `rsp_valid_o=1`; `rsp_word_o=res_q` and `rsp_id_o=id_q` are stable while `rsp_ready_i=0`.
  - On `rsp_ready_i=1`, go to IDLE.
  - No request is accepted in DONE; there is always one IDLE cycle between words.
- Requester inputs are sampled only at the handshake. Later changes are ignored.
- `cnt` is `$clog2(BYTES)` bits wide, minimum 1. There is no wrap-around beyond BYTES-1.
- The S-box is instantiated once inside this block. Its input is driven with byte 0 of `word_q` outside SUB, to keep the input deterministic.

## Timing
- **Reset values** (applied by reset regardless of the current state, including mid-SUB or DONE): state IDLE, `last=1` (so req0 wins the first tie), `cnt=0`, `res_q=0`, `rsp_valid_o=0`, `rsp_id_o=0`, `rsp_word_o=0`, `busy_o=0`, both `reqK_ready_o=0`. Any in-flight word is discarded with no response.
- **Latency without macro**: handshake in cycle T, SUB in T+1..T+BYTES, `rsp_valid_o` high from T+BYTES+1.
- **Latency with macro**: one extra cycle, so `rsp_valid_o` is high from T+BYTES+2.
- **Best-case throughput**: one word per BYTES+2 cycles without the macro, BYTES+3 with it, when `rsp_ready_i` is held high.
- **Simultaneous events**: a new request arriving while DONE is handshaking is accepted no earlier than the following IDLE cycle. Requesters holding valid through backpressure lose nothing.

## Configuration
- `AESPIM_SBOX_OUT_REG_EN` defined:
  - the S-box output is registered before the write into `res_q`;
  - the DRAIN state is present;
  - latency is +1 cycle;
  - the combinational path `word_q → S-box → res_q` is broken for timing.
- Not defined: the S-box output is written directly, there is no DRAIN state, and latency is as listed first under Timing.

## Test plan
- **Forward substitution**: req0 `0x53020100`, enc=1, `rsp_ready_i=1`. Require `rsp_word_o=0xED777C63` and `rsp_id_o=0`, with valid exactly 5 cycles after the handshake (6 with the macro).
- **Inverse substitution**: req1 `0xED777C63`, enc=0. Require `0x53020100` with `rsp_id_o=1`.
- **Round-robin**: both valid continuously after reset.
  - Grants must follow 0,1,0,1.
  - req1 `0xFFFFFFFF` enc=1 must return `0x16161616`.
  - req0 `0x00000000` enc=1 must return `0x63636363`.
- **Backpressure**: hold `rsp_ready_i=0` for 10 cycles in DONE. Require valid, word and ID stable, both ready outputs 0, then return to IDLE one cycle after `rsp_ready_i=1`.
- **Reset mid-SUB**: assert `rst_i` at `cnt=2`. Next cycle require all outputs at their reset values, with no `rsp_valid_o` afterwards for the aborted word.
- **Input change after accept**: change `req0_word_i` during SUB. The result must reflect only the word latched at the handshake.

Source files
------------

// File: rtl/aespim_sbox_sched.sv
// Byte-serial scheduler sharing one AES S-box between a column requester and a key-expansion requester.
// Optional macro AESPIM_SBOX_OUT_REG_EN registers the S-box output and adds a DRAIN state.

module aespim_bSbox (
    input  logic [7:0] i_data,
    input  logic       i_encrypt,
    output logic [7:0] o_data
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] w_pre;
    logic [7:0] w_inv;

    assign w_pre  = i_encrypt ? i_data : aff_inv(i_data);
    assign w_inv  = gf_inv(w_pre);
    assign o_data = i_encrypt ? aff_fwd(w_inv) : w_inv;

endmodule

// state | meaning
// IDLE  | arbitrate, accept one word
// SUB   | stream byte cnt through the S-box, LSB first
// DRAIN | write the last registered S-box byte (macro builds only)
// DONE  | hold result until consumer takes it
module aespim_sbox_sched #(
    parameter int BYTES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [8*BYTES-1:0] req0_word_i,
    input  logic               req0_enc_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [8*BYTES-1:0] req1_word_i,
    input  logic               req1_enc_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [8*BYTES-1:0] rsp_word_o,
    output logic               busy_o
);

    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SUB   = 2'd1,
`ifdef AESPIM_SBOX_OUT_REG_EN
        S_DRAIN = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last;
    logic [CW-1:0]         r_cnt;
    logic [BYTES-1:0][7:0] r_word;
    logic [BYTES-1:0][7:0] r_res;
    logic                  r_enc;
    logic                  r_id;
    logic                  w_grant0;
    logic                  w_grant1;
    logic [7:0]            w_sbox_in;
    logic [7:0]            w_sbox_out;
`ifdef AESPIM_SBOX_OUT_REG_EN
    logic [7:0]            r_sbox_q;
`endif

    // r_last=1 means requester 1 was served last, so requester 0 wins a tie.
    assign w_grant0 = req0_valid_i & (~req1_valid_i | r_last);
    assign w_grant1 = req1_valid_i & (~req0_valid_i | ~r_last);

    assign w_sbox_in  = (r_state == S_SUB) ? r_word[r_cnt] : r_word[0];
    assign rsp_word_o = r_res;
    assign rsp_id_o   = r_id;

    aespim_bSbox u_sbox (
        .i_data    (w_sbox_in),
        .i_encrypt (r_enc),
        .o_data    (w_sbox_out)
    );

    always_comb begin
        w_next       = r_state;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        rsp_valid_o  = 1'b0;
        busy_o       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                req0_ready_o = w_grant0 & ~rst_i;
                req1_ready_o = w_grant1 & ~rst_i;
                if (w_grant0 | w_grant1) w_next = S_SUB;
            end
            S_SUB: begin
                if (r_cnt == CNT_LAST) begin
`ifdef AESPIM_SBOX_OUT_REG_EN
                    w_next = S_DRAIN;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef AESPIM_SBOX_OUT_REG_EN
            S_DRAIN: begin
                w_next = S_DONE;
            end
`endif
            S_DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_cnt    <= '0;
            r_word   <= '0;
            r_res    <= '0;
            r_enc    <= 1'b0;
            r_id     <= 1'b0;
`ifdef AESPIM_SBOX_OUT_REG_EN
            r_sbox_q <= 8'h00;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req0_ready_o | req1_ready_o) begin
                        r_word <= req1_ready_o ? req1_word_i : req0_word_i;
                        r_enc  <= req1_ready_o ? req1_enc_i : req0_enc_i;
                        r_id   <= req1_ready_o;
                        r_last <= req1_ready_o;
                        r_cnt  <= '0;
                    end
                end
                S_SUB: begin
`ifdef AESPIM_SBOX_OUT_REG_EN
                    // Each registered byte lands one cycle late, at the previous lane.
                    r_sbox_q <= w_sbox_out;
                    if (r_cnt != '0) r_res[r_cnt - 1'b1] <= r_sbox_q;
`else
                    r_res[r_cnt] <= w_sbox_out;
`endif
                    if (r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
                end
`ifdef AESPIM_SBOX_OUT_REG_EN
                S_DRAIN: begin
                    r_res[r_cnt] <= r_sbox_q;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aespim_sbox_sched.sv
// Self-checking bench for aespim_sbox_sched: scoreboard of expected words, one task per scenario.

module tb_aespim_sbox_sched;

    localparam int BYTES = 4;
`ifdef AESPIM_SBOX_OUT_REG_EN
    localparam int LAT = BYTES + 2;
`else
    localparam int LAT = BYTES + 1;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req0_valid_i, req0_ready_o, req0_enc_i;
    logic [31:0] req0_word_i;
    logic        req1_valid_i, req1_ready_o, req1_enc_i;
    logic [31:0] req1_word_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o, busy_o;
    logic [31:0] rsp_word_o;

    aespim_sbox_sched #(.BYTES(BYTES)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_word_i  (req0_word_i),
        .req0_enc_i   (req0_enc_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_word_i  (req1_word_i),
        .req1_enc_i   (req1_enc_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_id_o     (rsp_id_o),
        .rsp_word_o   (rsp_word_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic        id;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic send(input logic k, input logic [31:0] w, input logic e,
                        input logic [31:0] expw, output int hs_cyc);
        if (k) begin
            req1_word_i = w; req1_enc_i = e; req1_valid_i = 1'b1;
        end else begin
            req0_word_i = w; req0_enc_i = e; req0_valid_i = 1'b1;
        end
        hs_cyc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if ((k ? req1_ready_o : req0_ready_o) === 1'b1) begin
                hs_cyc = cyc;
                break;
            end
        end
        n_cmp++;
        if (hs_cyc < 0) begin
            n_bad++;
            $display("FAIL send_accept req%0d: ready never seen in 50 cycles, required ready=1", k);
        end else begin
            sb_q.push_back('{k, expw});
        end
        @(posedge clk_i); #1;
        if (k) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
    endtask

    task automatic recv(input string name, input int hs_cyc);
        exp_t e;
        int   got;
        got = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) begin
                got = cyc;
                break;
            end
        end
        n_cmp++;
        if (got < 0) begin
            n_bad++;
            $display("FAIL %s_timeout: rsp_valid never seen in 100 cycles", name);
        end else if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s_unexpected: response id=%0d word=%h with empty scoreboard", name, rsp_id_o, rsp_word_o);
        end else begin
            e = sb_q.pop_front();
            if (rsp_word_o !== e.word) begin
                n_bad++;
                $display("FAIL %s_word: got %h required %h", name, rsp_word_o, e.word);
            end
            n_cmp++;
            if (rsp_id_o !== e.id) begin
                n_bad++;
                $display("FAIL %s_id: got %0d required %0d", name, rsp_id_o, e.id);
            end
            n_cmp++;
            if (got - hs_cyc != LAT) begin
                n_bad++;
                $display("FAIL %s_latency: got %0d required %0d", name, got - hs_cyc, LAT);
            end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if ({req0_ready_o, req1_ready_o} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ready: got %b required 00", {req0_ready_o, req1_ready_o});
        end
        n_cmp++;
        if ({rsp_valid_o, rsp_id_o, busy_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: valid/id/busy got %b required 000", {rsp_valid_o, rsp_id_o, busy_o});
        end
        n_cmp++;
        if (rsp_word_o !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_word: got %h required 00000000", rsp_word_o);
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b0;
    endtask

    task automatic test_forward();
        int hs;
        send(1'b0, 32'h53020100, 1'b1, 32'hED777C63, hs);
        recv("forward", hs);
    endtask

    task automatic test_inverse();
        int hs;
        send(1'b1, 32'hED777C63, 1'b0, 32'h53020100, hs);
        recv("inverse", hs);
    endtask

    task automatic test_input_change();
        int hs;
        send(1'b0, 32'h53020100, 1'b1, 32'hED777C63, hs);
        req0_word_i = 32'hFFFFFFFF;
        req0_enc_i  = 1'b0;
        recv("input_change", hs);
    endtask

    task automatic test_round_robin();
        logic grants[$];
        int   gcyc[$];
        int   nrsp;
        exp_t e;
        logic exp_g[4];
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
        do_reset();
        req0_word_i = 32'h00000000; req0_enc_i = 1'b1;
        req1_word_i = 32'hFFFFFFFF; req1_enc_i = 1'b1;
        req0_valid_i = 1'b1;
        req1_valid_i = 1'b1;
        nrsp = 0;
        for (int i = 0; i < 200 && nrsp < 4; i++) begin
            @(negedge clk_i);
            if (req0_ready_o === 1'b1 && req1_ready_o === 1'b1) begin
                n_cmp++; n_bad++;
                $display("FAIL rr_double_grant: both ready at cycle %0d, required one", cyc);
            end else if (req0_ready_o === 1'b1) begin
                grants.push_back(1'b0); gcyc.push_back(cyc);
                sb_q.push_back('{1'b0, 32'h63636363});
            end else if (req1_ready_o === 1'b1) begin
                grants.push_back(1'b1); gcyc.push_back(cyc);
                sb_q.push_back('{1'b1, 32'h16161616});
            end
            if (rsp_valid_o === 1'b1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                nrsp++;
                n_cmp++;
                if (rsp_word_o !== e.word || rsp_id_o !== e.id) begin
                    n_bad++;
                    $display("FAIL rr_rsp%0d: got id=%0d word=%h required id=%0d word=%h",
                             nrsp, rsp_id_o, rsp_word_o, e.id, e.word);
                end
            end
        end
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        n_cmp++;
        if (nrsp != 4 || grants.size() != 4) begin
            n_bad++;
            $display("FAIL rr_count: got %0d responses %0d grants required 4 and 4", nrsp, grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (grants[i] !== exp_g[i]) begin
                    n_bad++;
                    $display("FAIL rr_grant%0d: got %0d required %0d", i, grants[i], exp_g[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (gcyc[i] - gcyc[i-1] != LAT + 1) begin
                    n_bad++;
                    $display("FAIL rr_spacing%0d: got %0d required %0d", i, gcyc[i] - gcyc[i-1], LAT + 1);
                end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_backpressure();
        int   hs;
        int   got;
        exp_t e;
        rsp_ready_i = 1'b0;
        send(1'b0, 32'h00000000, 1'b0, 32'h52525252, hs);
        req0_word_i = 32'h01010101; req0_enc_i = 1'b1; req0_valid_i = 1'b1;
        req1_word_i = 32'h00000000; req1_enc_i = 1'b1; req1_valid_i = 1'b1;
        got = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) begin
                got = cyc;
                break;
            end
        end
        n_cmp++;
        if (got < 0 || sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL bp_timeout: rsp_valid never seen in 100 cycles");
            req0_valid_i = 1'b0; req1_valid_i = 1'b0; rsp_ready_i = 1'b1;
            sb_q.delete();
            return;
        end
        e = sb_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({rsp_valid_o, rsp_id_o, rsp_word_o, req0_ready_o, req1_ready_o} !== {1'b1, e.id, e.word, 2'b00}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got valid=%b id=%0d word=%h rdy=%b%b required valid=1 id=%0d word=%h rdy=00",
                         i, rsp_valid_o, rsp_id_o, rsp_word_o, req0_ready_o, req1_ready_o, e.id, e.word);
            end
            @(negedge clk_i);
        end
        @(posedge clk_i); #1 rsp_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, rsp_valid_o, req0_ready_o, req1_ready_o} !== 4'b0001) begin
            n_bad++;
            $display("FAIL bp_release: busy/valid/rdy0/rdy1 got %b required 0001",
                     {busy_o, rsp_valid_o, req0_ready_o, req1_ready_o});
        end
        hs = cyc;
        if (req1_ready_o === 1'b1) sb_q.push_back('{1'b1, 32'h63636363});
        @(posedge clk_i); #1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        recv("bp_next", hs);
    endtask

    task automatic test_reset_mid_sub();
        int hs;
        int seen;
        send(1'b0, 32'h11223344, 1'b1, 32'h0, hs);
        sb_q.delete();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if ({rsp_valid_o, rsp_id_o, busy_o, req0_ready_o, req1_ready_o} !== 5'b00000 || rsp_word_o !== 32'h0) begin
            n_bad++;
            $display("FAIL midsub_reset: valid/id/busy/rdy got %b word %h required 00000 word 00000000",
                     {rsp_valid_o, rsp_id_o, busy_o, req0_ready_o, req1_ready_o}, rsp_word_o);
        end
        @(posedge clk_i); #1 rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL midsub_no_rsp: rsp_valid high %0d cycles required 0", seen);
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        req0_valid_i = 1'b0; req0_word_i = '0; req0_enc_i = 1'b0;
        req1_valid_i = 1'b0; req1_word_i = '0; req1_enc_i = 1'b0;
        rsp_ready_i  = 1'b1;
        test_reset();
        test_forward();
        test_inverse();
        test_input_change();
        test_round_robin();
        test_backpressure();
        test_reset_mid_sub();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
